// File: rtl/mem_access.sv
// mem_access: MIPS memory-access stage. Passes execute results straight to
// writeback, or runs one word load/store over a req/ack data-memory port.
module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [63:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [1:0]  ex_mem_op,
    input  logic [4:0]  ex_dest,
    input  logic        ex_reg_write,
    output logic        ex_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_dest,
    output logic [31:0] wb_data,
    output logic        wb_reg_write,
    output logic        align_err,
    output logic        bus_err
);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_WAIT   = 1'b1;
    localparam logic [1:0] OP_LW    = 2'b01;
    localparam logic [1:0] OP_SW    = 2'b10;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [0:0]  state;
    logic [7:0]  cnt;
    logic [4:0]  dest_q;
    logic        reg_write_q;
    logic [31:0] ex_addr;
    logic        is_mem;
    logic        misaligned;
    logic        unused_hi;

    assign ex_addr    = ex_result[31:0];
    assign unused_hi  = ^ex_result[63:32];
    assign is_mem     = (ex_mem_op == OP_LW) || (ex_mem_op == OP_SW);
    assign misaligned = (ex_addr[1:0] != 2'b00);

    // Request and stall are pure decodes of the state register, so neither
    // ex_valid nor dmem_ack can reach them combinationally.
    assign ex_stall = (state == S_WAIT);
    assign dmem_req = (state == S_WAIT);

    // NOTE: every register here is sequential state, so all updates use <=;
    // blocking assignments would let later statements see half-updated values.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset too because every output must
        // read 0 after reset, not just the control state.
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            dest_q       <= '0;
            reg_write_q  <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            wb_valid     <= 1'b0;
            wb_dest      <= '0;
            wb_data      <= '0;
            wb_reg_write <= 1'b0;
            align_err    <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            wb_valid  <= 1'b0;
            align_err <= 1'b0;
            bus_err   <= 1'b0;

            if (state == S_IDLE) begin
                if (ex_valid) begin
                    if (!is_mem) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= ex_addr;
                        wb_dest      <= ex_dest;
                        wb_reg_write <= ex_reg_write;
                    end else if (misaligned) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= ex_addr;
                        wb_dest      <= ex_dest;
                        wb_reg_write <= 1'b0;
                        align_err    <= 1'b1;
                    end else begin
                        dmem_addr   <= ex_addr;
                        dmem_we     <= (ex_mem_op == OP_SW);
                        dmem_wdata  <= ex_store_data;
                        dest_q      <= ex_dest;
                        reg_write_q <= ex_reg_write;
                        cnt         <= '0;
                        state       <= S_WAIT;
                    end
                end
            end else begin
                // An ack on the timeout cycle wins: it is tested first.
                if (dmem_ack) begin
                    state    <= S_IDLE;
                    wb_valid <= 1'b1;
                    wb_dest  <= dest_q;
                    if (dmem_we) begin
                        wb_data      <= dmem_addr;
                        wb_reg_write <= 1'b0;
                    end else begin
                        wb_data      <= dmem_rdata;
                        wb_reg_write <= reg_write_q;
                    end
                end else if (cnt == CNT_LAST) begin
                    state        <= S_IDLE;
                    wb_valid     <= 1'b1;
                    wb_dest      <= dest_q;
                    wb_data      <= dmem_addr;
                    wb_reg_write <= 1'b0;
                    bus_err      <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: per-period expectation timeline built
// from transaction rules, compared against the DUT on every falling edge.
module tb_mem_access;
    localparam int T    = 4;
    localparam int MAXP = 8192;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic [63:0] ex_result = '0;
    logic [31:0] ex_store_data = '0;
    logic [1:0]  ex_mem_op = '0;
    logic [4:0]  ex_dest = '0;
    logic        ex_reg_write = 1'b0;
    logic        ex_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        wb_reg_write;
    logic        align_err;
    logic        bus_err;

    mem_access #(.TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_result(ex_result), .ex_store_data(ex_store_data),
        .ex_mem_op(ex_mem_op), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_stall(ex_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
        .wb_reg_write(wb_reg_write), .align_err(align_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; "period p" is the time after edge p.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s period=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Expected behaviour per period.
    bit        e_rst    [MAXP];
    bit        e_req    [MAXP];
    bit        e_we     [MAXP];
    bit [31:0] e_addr   [MAXP];
    bit [31:0] e_wdata  [MAXP];
    bit        e_wbv    [MAXP];
    bit [31:0] e_data   [MAXP];
    bit        e_data_k [MAXP];
    bit [4:0]  e_dest   [MAXP];
    bit        e_dest_k [MAXP];
    bit        e_rw     [MAXP];
    bit        e_al     [MAXP];
    bit        e_bus    [MAXP];

    // Held writeback fields as the model sees them.
    bit [31:0] h_data;
    bit [4:0]  h_dest;
    bit        h_rw;
    bit        h_data_k = 1'b1;
    bit        h_dest_k = 1'b1;
    int        req_run = 0;
    int        last_req_len = 0;
    bit        prev_req = 1'b0;
    int        last_rise = -1;
    int        prev_rise = -1;

    always @(negedge clk) begin
        if (cyc > 0 && cyc < MAXP) begin
            if (e_rst[cyc]) begin
                h_data = '0; h_dest = '0; h_rw = 1'b0;
                h_data_k = 1'b1; h_dest_k = 1'b1;
                check("rst_we", dmem_we, 0);
                check("rst_addr", dmem_addr, 0);
                check("rst_wdata", dmem_wdata, 0);
            end else if (e_wbv[cyc]) begin
                h_rw     = e_rw[cyc];
                h_data_k = e_data_k[cyc];
                h_dest_k = e_dest_k[cyc];
                if (e_data_k[cyc]) h_data = e_data[cyc];
                if (e_dest_k[cyc]) h_dest = e_dest[cyc];
            end
            check("wb_valid", wb_valid, e_wbv[cyc]);
            check("align_err", align_err, e_al[cyc]);
            check("bus_err", bus_err, e_bus[cyc]);
            check("dmem_req", dmem_req, e_req[cyc]);
            check("ex_stall", ex_stall, e_req[cyc]);
            if (e_req[cyc]) begin
                check("dmem_we", dmem_we, e_we[cyc]);
                check("dmem_addr", dmem_addr, e_addr[cyc]);
                check("dmem_wdata", dmem_wdata, e_wdata[cyc]);
            end
            check("wb_reg_write", wb_reg_write, h_rw);
            if (h_data_k) check("wb_data", wb_data, h_data);
            if (h_dest_k) check("wb_dest", wb_dest, h_dest);
        end
        if (dmem_req === 1'b1) begin
            req_run++;
            if (!prev_req) begin prev_rise = last_rise; last_rise = cyc; end
        end else if (req_run > 0) begin
            last_req_len = req_run;
            req_run = 0;
        end
        prev_req = (dmem_req === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle(input bit ack);
        ex_valid      = 1'b0;
        ex_result     = {$urandom(), $urandom()};
        ex_store_data = $urandom();
        ex_mem_op     = 2'($urandom_range(0, 3));
        ex_dest       = 5'($urandom_range(0, 31));
        ex_reg_write  = 1'($urandom_range(0, 1));
        dmem_ack      = ack;
        dmem_rdata    = $urandom();
    endtask

    // Upstream noise while stalled; must be ignored.
    task automatic drive_wait_junk();
        drive_idle(1'b0);
        ex_valid = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive_idle(1'($urandom_range(0, 1)));
            tick();
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 1; i <= n; i++) e_rst[cyc + i] = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive_wait_junk();
            tick();
        end
        reset = 1'b0;
    endtask

    // One instruction. k = cycle of the ack counted from the first req cycle
    // (1..T), or 0 for no ack (timeout). Returns in the writeback period.
    task automatic do_op(input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] dest,
                         input bit rw, input int k, input logic [31:0] rdv,
                         input bit ack_idle);
        int n;
        int len;
        int w;
        n = cyc + 1;
        ex_valid      = 1'b1;
        ex_result     = {$urandom(), addr};
        ex_store_data = sd;
        ex_mem_op     = op;
        ex_dest       = dest;
        ex_reg_write  = rw;
        dmem_ack      = ack_idle;
        dmem_rdata    = $urandom();
        if (op == 2'b00 || op == 2'b11) begin
            e_wbv[n] = 1'b1; e_data[n] = addr; e_data_k[n] = 1'b1;
            e_dest[n] = dest; e_dest_k[n] = 1'b1; e_rw[n] = rw;
            tick();
        end else if (addr[1:0] != 2'b00) begin
            e_wbv[n] = 1'b1; e_al[n] = 1'b1; e_rw[n] = 1'b0;
            e_data_k[n] = 1'b0; e_dest_k[n] = 1'b0;
            tick();
        end else begin
            len = (k == 0) ? T : k;
            for (int i = 0; i < len; i++) begin
                e_req[n + i]   = 1'b1;
                e_we[n + i]    = (op == 2'b10);
                e_addr[n + i]  = addr;
                e_wdata[n + i] = sd;
            end
            w = n + len;
            e_wbv[w] = 1'b1; e_dest[w] = dest; e_dest_k[w] = 1'b1;
            if (k == 0) begin
                e_bus[w] = 1'b1; e_rw[w] = 1'b0; e_data_k[w] = 1'b0;
            end else if (op == 2'b10) begin
                e_rw[w] = 1'b0; e_data[w] = addr; e_data_k[w] = 1'b1;
            end else begin
                e_rw[w] = rw; e_data[w] = rdv; e_data_k[w] = 1'b1;
            end
            tick();
            for (int i = 0; i < len; i++) begin
                drive_wait_junk();
                if (k != 0 && i == len - 1) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdv;
                end
                tick();
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog period=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    int            mid_n;
    logic [1:0]    r_op;
    logic [31:0]   r_addr;
    int            r_k;

    initial begin
        // Reset held two cycles, then a plain ALU result.
        do_reset(2);
        check("lit_rst_req", dmem_req, 0);
        check("lit_rst_wbv", wb_valid, 0);
        do_op(2'b00, 32'h5, 32'h0, 5'd3, 1'b1, 0, 32'h0, 1'b0);
        check("lit_alu_wbv", wb_valid, 1);
        check("lit_alu_data", wb_data, 32'h5);
        check("lit_alu_dest", wb_dest, 5'd3);
        check("lit_alu_stall", ex_stall, 0);
        idle(1);

        // Load with ack on the third request cycle.
        do_op(2'b01, 32'h100, 32'h0, 5'd7, 1'b1, 3, 32'hDEADBEEF, 1'b0);
        check("lit_ld_wbv", wb_valid, 1);
        check("lit_ld_data", wb_data, 32'hDEADBEEF);
        check("lit_ld_rw", wb_reg_write, 1);
        idle(1);
        check("lit_ld_reqlen", last_req_len, 3);

        // Store then immediate load of the same word.
        do_op(2'b10, 32'h200, 32'hCAFEF00D, 5'd9, 1'b1, 1, 32'h0, 1'b0);
        check("lit_st_rw", wb_reg_write, 0);
        check("lit_st_data", wb_data, 32'h200);
        do_op(2'b01, 32'h200, 32'h0, 5'd10, 1'b1, 1, 32'hCAFEF00D, 1'b0);
        check("lit_b2b_gap", last_rise - prev_rise, 2);
        check("lit_b2b_data", wb_data, 32'hCAFEF00D);
        idle(1);

        // Misaligned load.
        do_op(2'b01, 32'h102, 32'h0, 5'd4, 1'b1, 1, 32'h0, 1'b0);
        check("lit_mis_al", align_err, 1);
        check("lit_mis_wbv", wb_valid, 1);
        check("lit_mis_rw", wb_reg_write, 0);
        check("lit_mis_req", dmem_req, 0);
        idle(1);

        // Timeout, then a late ack two cycles later.
        do_op(2'b01, 32'h300, 32'h0, 5'd5, 1'b1, 0, 32'h0, 1'b0);
        check("lit_to_bus", bus_err, 1);
        check("lit_to_rw", wb_reg_write, 0);
        drive_idle(1'b0); tick();
        drive_idle(1'b0); tick();
        drive_idle(1'b1); tick();
        drive_idle(1'b0); tick();
        check("lit_to_reqlen", last_req_len, T);

        // Reset in the second WAIT cycle.
        mid_n = cyc + 1;
        ex_valid = 1'b1; ex_result = {32'h0, 32'h400}; ex_mem_op = 2'b01;
        ex_dest = 5'd6; ex_reg_write = 1'b1; ex_store_data = 32'h0; dmem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e_req[mid_n + i] = 1'b1; e_we[mid_n + i] = 1'b0;
            e_addr[mid_n + i] = 32'h400; e_wdata[mid_n + i] = 32'h0;
        end
        tick();
        drive_wait_junk();
        tick();
        drive_wait_junk();
        reset = 1'b1;
        e_rst[mid_n + 2] = 1'b1;
        tick();
        reset = 1'b0;
        check("lit_mid_req", dmem_req, 0);
        check("lit_mid_wbv", wb_valid, 0);
        idle(2);

        // Ack on exactly the timeout cycle.
        do_op(2'b01, 32'h500, 32'h0, 5'd8, 1'b1, T, 32'h12345678, 1'b0);
        check("lit_tie_bus", bus_err, 0);
        check("lit_tie_wbv", wb_valid, 1);
        check("lit_tie_data", wb_data, 32'h12345678);
        idle(1);

        // Randomized traffic.
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 9) < 3)
                r_op = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
            else
                r_op = 2'($urandom_range(1, 2));
            r_addr = $urandom();
            if ($urandom_range(0, 4) != 0) r_addr[1:0] = 2'b00;
            r_k = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, T));
            do_op(r_op, r_addr, $urandom(), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), r_k, $urandom(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(3);
        @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the 32-bit MIPS pipeline, sitting directly after the execute stage and before register writeback. It consumes the execute result (ALU value / effective address) and either passes it through to writeback in one cycle or performs a word load/store on the data-memory port using a req/ack handshake. While a memory transaction is outstanding, it stalls the upstream pipeline. It flags misaligned and timed-out accesses.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum cycles `dmem_req` stays high without `dmem_ack` before the access is aborted. Legal range 2–255.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ex_valid` in 1: execute output valid this cycle.
- `ex_result` in 64: execute result; `[31:0]` is the ALU value / effective address, `[63:32]` is ignored.
- `ex_store_data` in 32: rt value for a store.
- `ex_mem_op` in 2: 00 none, 01 load word, 10 store word, 11 treated as none.
- `ex_dest` in 5: destination register.
- `ex_reg_write` in 1: instruction writes a register.
- `ex_stall` out 1: upstream must hold its outputs and `ex_valid`.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 32: word-aligned address.
- `dmem_wdata` out 32: store data.
- `dmem_ack` in 1: memory completion, one-cycle pulse.
- `dmem_rdata` in 32: load data, valid with `dmem_ack`.
- `wb_valid` out 1: writeback packet valid (one-cycle pulse).
- `wb_dest` out 5: writeback register.
- `wb_data` out 32: writeback data.
- `wb_reg_write` out 1: perform the register write.
- `align_err` out 1: one-cycle pulse when the address has `[1:0] != 0`.
- `bus_err` out 1: one-cycle pulse when the access times out.

## Operation
States: IDLE and WAIT.

IDLE, when `ex_valid=1`:
- **None-op:** the next cycle presents `wb_valid=1`, `wb_data=ex_result[31:0]`, and `wb_dest`/`wb_reg_write` copied from the inputs. State stays IDLE.
- **Load/store with `ex_result[1:0]!=0`:** no memory request is issued. The next cycle presents `align_err=1` and `wb_valid=1` with `wb_reg_write=0`. State stays IDLE.
- **Aligned load/store:** the stage latches `dmem_addr=ex_result[31:0]`, `dmem_we` (1 for a store), `dmem_wdata=ex_store_data`, and the destination fields. It then sets `dmem_req=1`, clears the timeout counter, and moves to WAIT.

WAIT:
- `dmem_req`, `dmem_addr`, `dmem_we`, and `dmem_wdata` are held stable. The counter increments every cycle.
- **`dmem_ack=1`:** the stage drops `dmem_req` at the next edge and returns to IDLE. The next cycle presents `wb_valid=1`.
  - Load: `wb_data=dmem_rdata` as sampled on the ack cycle; `wb_reg_write` is the latched value.
  - Store: `wb_reg_write=0`; `wb_data` is the address.
- **Timeout (counter reaches `TIMEOUT-1` with no ack):** the stage drops `dmem_req`, returns to IDLE, and pulses `bus_err`. It also emits `wb_valid=1` with `wb_reg_write=0`.
- An ack arriving on the same cycle the timeout fires takes priority: the access completes normally.

General rules:
- `dmem_ack` is ignored in IDLE, including a late ack after a timeout or a reset.
- `ex_valid` is ignored in WAIT; upstream is holding because `ex_stall=1`.

## Timing
- Reset value of every output is 0: `ex_stall`, `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `wb_valid`, `wb_dest`, `wb_data`, `wb_reg_write`, `align_err`, `bus_err`. The timeout counter is also 0.
- Reset asserted in WAIT: `dmem_req=0` after that edge and state is IDLE. No `wb_valid` or error pulse is produced for the aborted access.
- `ex_stall = (state==WAIT)`, decoded from registered state only. There is no combinational path from `ex_valid` or `dmem_ack`.
- None-op latency: accept on edge N, `wb_valid` during cycle N+1.
- Memory access, accepted on edge N:
  - `dmem_req` and `ex_stall` are high from cycle N+1.
  - With `dmem_ack` in cycle N+k (k≥1): `dmem_req` and `ex_stall` go low in N+k+1, `wb_valid` is high in N+k+1, and a new input can be accepted on edge N+k+1.
  - Minimum back-to-back memory throughput is one access every 2 cycles.
- Timeout: with no ack, `bus_err` and `wb_valid` are high in cycle N+TIMEOUT+1, and `dmem_req` is high for exactly `TIMEOUT` cycles.
- `wb_valid`, `align_err`, and `bus_err` are single-cycle pulses; the `wb_*` data fields hold their value between pulses.

## Test plan
- **Reset:** hold `reset` 2 cycles -> all outputs 0. Drive ALU-op `ex_result=0x5`, `ex_dest=3`, `ex_reg_write=1` -> next cycle `wb_valid=1`, `wb_data=0x5`, `wb_dest=3`, `ex_stall=0` throughout.
- **Load:** load at `0x100`, ack after 3 cycles with `rdata=0xDEADBEEF` -> `dmem_req` high exactly 3 cycles, `dmem_we=0`, `ex_stall` high 3 cycles, then `wb_valid=1`, `wb_data=0xDEADBEEF`, `wb_reg_write=1`.
- **Store then load, back-to-back:** store `0xCAFEF00D` to `0x200`, ack after 1 cycle, then an immediate load of `0x200` -> `dmem_we=1` with the correct `wdata`, store `wb_reg_write=0`, second `dmem_req` rises 2 cycles after the first `req` rose.
- **Misaligned:** load at `0x102` -> `dmem_req` never rises, `align_err=1` and `wb_valid=1` with `wb_reg_write=0` one cycle later.
- **Timeout:** with `TIMEOUT=4`, load with no ack -> `dmem_req` high 4 cycles, `bus_err=1` and `wb_reg_write=0`. A late ack 2 cycles after that produces no `wb_valid`.
- **Reset mid-WAIT, then tie:** assert `reset` in the 2nd WAIT cycle -> `dmem_req=0` next cycle and no `wb_valid`. A follow-up access with ack exactly on the timeout cycle -> normal completion, `bus_err=0`.
